reflet_ram_arbiter: RTL and testbench
=====================================

# reflet_ram_arbiter

Two-master arbiter sharing one single-port `reflet_ram16`-style RAM (one-cycle registered read) between the reflet CPU data port and a second requester such as a DMA or debug port. Round-robin grant on contention; one access in flight at a time. Sits between the masters' address/data buses and the RAM, replacing the direct CPU-to-RAM connection of the simulation top levels. Unselected read data is driven to zero so results can be OR-merged with ROM data on the CPU bus.

## Interface
Parameters:
- `wordsize`, 16, data width
- `addrSize`, 15, RAM word-address width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request; hold high with stable addr/data until ready
- `m0_addr`, `m1_addr`  in  addrSize  word address
- `m0_data_out`, `m1_data_out`  in  wordsize  write data from master
- `m0_write_en`, `m1_write_en`  in  1  1 = write, 0 = read
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse
- `m0_data_in`, `m1_data_in`  out  wordsize  read data, valid only while own ready = 1, else 0
- `ram_enable`  out  1  RAM select
- `ram_addr`  out  addrSize  RAM address
- `ram_data_in`  out  wordsize  RAM write data
- `ram_write_en`  out  1  RAM write strobe
- `ram_data_out`  in  wordsize  RAM read data, valid the cycle after the address phase

## Operation
- States: IDLE, ACCESS (address phase), RESPOND (data phase). Register `owner` (0/1) and `last` (last master served).
- IDLE: at rising edge, if any req high -> pick winner, latch its addr/data/write_en into RAM output registers, `owner` <= winner, -> ACCESS. No req -> stay.
- Pick: one requester -> that one; both -> the master != `last`.
- ACCESS: `ram_enable`=1 with latched signals for exactly one cycle; RAM performs the write or read at the ending edge. -> RESPOND unconditionally; `last` <= `owner`.
- RESPOND: `mX_ready`=1 for `owner`; `mX_data_in` = `ram_data_out` for a read, 0 for a write. `ram_enable`=`ram_write_en`=0. At ending edge the owner's req is ignored; if the other master's req is high -> latch it, -> ACCESS; else -> IDLE.
- A master dropping req after grant does not abort: the access completes and the ready pulse is still issued.
- Req and addr changes outside IDLE/RESPOND sampling edges are ignored; only the latched copy drives the RAM.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `last`=1 (m0 wins first contention), `owner`=0, all outputs 0 immediately. If reset hits during ACCESS, `ram_write_en` falls at once; the write is not guaranteed, and no ready is issued.
- Latency: req high at edge E -> ACCESS during E..E+1 -> ready high during E+1..E+2, sampled by master at E+2.
- Throughput: alternating masters, one access per 2 cycles; same master back-to-back, one per 3 cycles (IDLE gap forced).
- Both ready outputs are never high together, and ram_enable is never high outside ACCESS.
- Outputs `ram_*` are registered; `mX_data_in` and `mX_ready` are decoded combinationally from state/owner plus `ram_data_out`.

## Structure
- Shared package `reflet_arbiter_pkg`: state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2) and master index constants.
- One sub-module, `reflet_rr_pick`: combinational 2-way round-robin picker (req[1:0], last) -> (valid, winner). The FSM, latches and output muxing stay in the top module.

## Test plan
- Single read: preload RAM[0x010]=0xBEEF; m0 read 0x010 -> ram_enable one cycle, m0_ready 2 cycles after req with m0_data_in=0xBEEF, m1 outputs stay 0.
- Single write: m1 writes 0x1234 to 0x7FFF -> ram_write_en one cycle with addr 0x7FFF; a following m0 read of 0x7FFF returns 0x1234.
- Contention after reset: both req same edge -> m0 served first, m1 ACCESS immediately in m0's RESPOND-following cycle; four alternating accesses take 8 cycles.
- Persistent requester: m0 req held high for 3 accesses, m1 idle -> ready pulses 3 cycles apart with an IDLE cycle between; m1 raising req mid-stream is served next.
- Abandoned request: m1 drops req during ACCESS -> access still completes, m1_ready pulses once, arbiter returns to IDLE.
- Reset mid-access: assert reset during ACCESS of a write -> all outputs 0 same cycle, no ready; after release, first contention grants m0.

Source files
------------

// File: rtl/reflet_arbiter_pkg.sv
// Shared types for the reflet RAM arbiter.
// State encoding and master indices.
package reflet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/reflet_rr_pick.sv
// Two-way round-robin picker.
// On contention the master that was not served last wins.
module reflet_rr_pick
  import reflet_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  // Pick the winner from the request pair and last-served master
  always_comb begin
    valid_o  = |req_i;
    winner_o = M0;
    unique case (1'b1)
      (req_i == 2'b11): winner_o = ~last_i;
      (req_i == 2'b10): winner_o = M1;
      default:          winner_o = M0;
    endcase
  end

endmodule

// File: rtl/reflet_ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM.
// One access in flight; round-robin on contention.
module reflet_ram_arbiter
  import reflet_arbiter_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int addrSize = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [addrSize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_data_out,
  input  logic                m0_write_en,
  output logic                m0_ready,
  output logic [wordsize-1:0] m0_data_in,
  input  logic                m1_req,
  input  logic [addrSize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_data_out,
  input  logic                m1_write_en,
  output logic                m1_ready,
  output logic [wordsize-1:0] m1_data_in,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en,
  input  logic [wordsize-1:0] ram_data_out
);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [addrSize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdata_q, wdata_d;

  logic [1:0] req_vec;
  logic [1:0] own_mask;
  logic       pick_valid;
  logic       pick_win;

  // The owner's own req is masked while it is being answered
  always_comb begin
    req_vec  = {m1_req, m0_req};
    own_mask = 2'b00;
    if (state_q == RESPOND) begin
      own_mask = owner_q ? 2'b10 : 2'b01;
    end
  end

  reflet_rr_pick u_pick (
    .req_i    (req_vec & ~own_mask),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_win)
  );

  // Next-state and latch selection
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, RESPOND: begin
        state_d = IDLE;
        if (pick_valid) begin
          state_d = ACCESS;
          owner_d = pick_win;
          en_d    = 1'b1;
          we_d    = pick_win ? m1_write_en : m0_write_en;
          wr_d    = we_d;
          addr_d  = pick_win ? m1_addr : m0_addr;
          wdata_d = pick_win ? m1_data_out : m0_data_out;
        end
      end
      ACCESS: begin
        state_d = RESPOND;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and RAM output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M1;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Ready and zero-gated read data for OR-merging
  always_comb begin
    m0_ready   = (state_q == RESPOND) && (owner_q == M0);
    m1_ready   = (state_q == RESPOND) && (owner_q == M1);
    m0_data_in = '0;
    m1_data_in = '0;
    if (m0_ready && !wr_q) m0_data_in = ram_data_out;
    if (m1_ready && !wr_q) m1_data_in = ram_data_out;
  end

  assign ram_enable   = en_q;
  assign ram_write_en = we_q;
  assign ram_addr     = addr_q;
  assign ram_data_in  = wdata_q;

endmodule

// File: tb/tb_reflet_ram_arbiter.sv
// Self-checking bench for reflet_ram_arbiter.
// Behavioural RAM plus per-master scoreboard queues.
module tb_reflet_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [14:0] m0_addr, m1_addr;
  logic [15:0] m0_data_out, m1_data_out;
  logic        m0_write_en, m1_write_en;
  logic        m0_ready, m1_ready;
  logic [15:0] m0_data_in, m1_data_in;
  logic        ram_enable, ram_write_en;
  logic [14:0] ram_addr;
  logic [15:0] ram_data_in, ram_data_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem  [0:32767];
  logic [15:0] refm [0:32767];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  always #5 clk = ~clk;

  reflet_ram_arbiter #(.wordsize(16), .addrSize(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_addr      (m0_addr),
    .m0_data_out  (m0_data_out),
    .m0_write_en  (m0_write_en),
    .m0_ready     (m0_ready),
    .m0_data_in   (m0_data_in),
    .m1_req       (m1_req),
    .m1_addr      (m1_addr),
    .m1_data_out  (m1_data_out),
    .m1_write_en  (m1_write_en),
    .m1_ready     (m1_ready),
    .m1_data_in   (m1_data_in),
    .ram_enable   (ram_enable),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
  );

  function automatic logic [15:0] init_val(int i);
    return 16'((i * 37 + 5) ^ 16'h3C00);
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
    mem[15'h010] = 16'hBEEF;
    ram_data_out = '0;
    forever begin
      @(posedge clk);
      if (ram_enable) begin
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
        else ram_data_out <= mem[ram_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  task automatic drive_m0(logic [14:0] a, logic we, logic [15:0] d);
    m0_req = 1'b1; m0_addr = a; m0_write_en = we; m0_data_out = d;
    if (we) begin refm[a] = d; exp0.push_back(16'h0); end
    else exp0.push_back(refm[a]);
  endtask

  task automatic drive_m1(logic [14:0] a, logic we, logic [15:0] d);
    m1_req = 1'b1; m1_addr = a; m1_write_en = we; m1_data_out = d;
    if (we) begin refm[a] = d; exp1.push_back(16'h0); end
    else exp1.push_back(refm[a]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 0; m0_addr = '0; m0_data_out = '0; m0_write_en = 0;
    m1_req = 0; m1_addr = '0; m1_data_out = '0; m1_write_en = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready, ram_enable, ram_write_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {m0_ready, m1_ready, ram_enable, ram_write_en});
    end
    checks++;
    if ({ram_addr, ram_data_in, m0_data_in, m1_data_in} !== 63'b0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wd=%h d0=%h d1=%h required 0",
               ram_addr, ram_data_in, m0_data_in, m1_data_in);
    end
    reset = 1'b1;
  endtask

  task automatic test_contention();
    logic [11:0] r0, r1;
    int n0, n1;
    r0 = '0; r1 = '0; n0 = 0; n1 = 0;
    @(negedge clk);
    drive_m0(15'h020, 1'b0, 16'h0);
    drive_m1(15'h030, 1'b0, 16'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (!ram_enable || ram_addr !== 15'h020) begin
          errors++;
          $display("FAIL cont_first: en=%b addr=%h required 1/020",
                   ram_enable, ram_addr);
        end
      end
      r0[k] = m0_ready; r1[k] = m1_ready;
      if (m0_ready) begin
        n0++;
        if (n0 == 2) m0_req = 1'b0;
        else drive_m0(15'h021, 1'b0, 16'h0);
      end
      if (m1_ready) begin
        n1++;
        if (n1 == 2) m1_req = 1'b0;
        else drive_m1(15'h031, 1'b0, 16'h0);
      end
    end
    checks++;
    if (r0 !== 12'h022) begin
      errors++;
      $display("FAIL cont_m0_slots: got %b required %b", r0, 12'h022);
    end
    checks++;
    if (r1 !== 12'h088) begin
      errors++;
      $display("FAIL cont_m1_slots: got %b required %b", r1, 12'h088);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive_m0(15'h010, 1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if ({ram_enable, ram_write_en, ram_addr, m0_ready} !== {2'b10, 15'h010, 1'b0}) begin
      errors++;
      $display("FAIL rd_access: en=%b we=%b addr=%h rdy=%b required 1/0/010/0",
               ram_enable, ram_write_en, ram_addr, m0_ready);
    end
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready, ram_enable} !== 3'b100) begin
      errors++;
      $display("FAIL rd_respond: rdy0=%b rdy1=%b en=%b required 1/0/0",
               m0_ready, m1_ready, ram_enable);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_ready, ram_enable} !== 2'b00) begin
      errors++;
      $display("FAIL rd_after: rdy0=%b en=%b required 0/0", m0_ready, ram_enable);
    end
  endtask

  task automatic test_single_write();
    bit seen;
    @(negedge clk);
    drive_m1(15'h7FFF, 1'b1, 16'h1234);
    @(negedge clk);
    checks++;
    if ({ram_enable, ram_write_en, ram_addr, ram_data_in} !== {2'b11, 15'h7FFF, 16'h1234}) begin
      errors++;
      $display("FAIL wr_access: en=%b we=%b addr=%h wd=%h required 1/1/7fff/1234",
               ram_enable, ram_write_en, ram_addr, ram_data_in);
    end
    @(negedge clk);
    checks++;
    if ({m1_ready, ram_write_en} !== 2'b10) begin
      errors++;
      $display("FAIL wr_respond: rdy1=%b we=%b required 1/0", m1_ready, ram_write_en);
    end
    m1_req = 1'b0;
    @(negedge clk);
    drive_m0(15'h7FFF, 1'b0, 16'h0);
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (m0_ready) begin seen = 1; m0_req = 1'b0; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wr_readback_timeout: m0_ready=0 required 1 within 6 cycles");
      m0_req = 1'b0;
    end
  endtask

  task automatic test_persistent();
    logic [14:0] a0 [4];
    logic        w0 [4];
    logic [15:0] d0 [4];
    logic [13:0] r0, r1;
    int n0;
    a0 = '{15'h040, 15'h040, 15'h041, 15'h041};
    w0 = '{1'b1, 1'b0, 1'b1, 1'b0};
    d0 = '{16'hA5A5, 16'h0, 16'h5A5A, 16'h0};
    r0 = '0; r1 = '0; n0 = 0;
    @(negedge clk);
    drive_m0(a0[0], w0[0], d0[0]);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      r0[k] = m0_ready; r1[k] = m1_ready;
      if (m0_ready) begin
        n0++;
        if (n0 == 4) m0_req = 1'b0;
        else drive_m0(a0[n0], w0[n0], d0[n0]);
        if (n0 == 3) drive_m1(15'h030, 1'b0, 16'h0);
      end
      if (m1_ready) m1_req = 1'b0;
    end
    checks++;
    if (r0 !== 14'h0892) begin
      errors++;
      $display("FAIL pers_m0_slots: got %b required %b", r0, 14'h0892);
    end
    checks++;
    if (r1 !== 14'h0200) begin
      errors++;
      $display("FAIL pers_m1_slots: got %b required %b", r1, 14'h0200);
    end
  endtask

  task automatic test_abandon();
    logic [5:0] r0, r1, en;
    r0 = '0; r1 = '0; en = '0;
    @(negedge clk);
    drive_m1(15'h031, 1'b0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r0[k] = m0_ready; r1[k] = m1_ready; en[k] = ram_enable;
      if (k == 0) m1_req = 1'b0;
    end
    checks++;
    if ({r0, r1, en} !== {6'b0, 6'b000010, 6'b000001}) begin
      errors++;
      $display("FAIL abandon: r0=%b r1=%b en=%b required 000000/000010/000001",
               r0, r1, en);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] r0, r1;
    r0 = '0; r1 = '0;
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 15'h050; m0_write_en = 1'b1; m0_data_out = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (ram_write_en !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: we=%b required 1", ram_write_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({m0_ready, m1_ready, ram_enable, ram_write_en, ram_addr, ram_data_in} !== 35'b0) begin
      errors++;
      $display("FAIL rmid_async: rdy=%b%b en=%b we=%b addr=%h wd=%h required 0",
               m0_ready, m1_ready, ram_enable, ram_write_en, ram_addr, ram_data_in);
    end
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_noready: rdy=%b%b required 00", m0_ready, m1_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    drive_m0(15'h020, 1'b0, 16'h0);
    drive_m1(15'h031, 1'b0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r0[k] = m0_ready; r1[k] = m1_ready;
      if (m0_ready) m0_req = 1'b0;
      if (m1_ready) m1_req = 1'b0;
    end
    checks++;
    if ({r0, r1} !== {6'b000010, 6'b001000}) begin
      errors++;
      $display("FAIL rmid_regrant: r0=%b r1=%b required 000010/001000", r0, r1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) refm[i] = init_val(i);
    refm[15'h010] = 16'hBEEF;
    fork
      begin : monitor
        logic [15:0] e;
        forever begin
          @(negedge clk);
          if (reset === 1'b1) begin
            checks++;
            if (m0_ready && m1_ready) begin
              errors++;
              $display("FAIL both_ready: m0=%b m1=%b required not both",
                       m0_ready, m1_ready);
            end
            checks++;
            if (m0_ready) begin
              if (exp0.size() == 0) begin
                errors++;
                $display("FAIL m0_extra_ready: ready=1 required no pending");
              end else begin
                e = exp0.pop_front();
                if (m0_data_in !== e) begin
                  errors++;
                  $display("FAIL m0_data: got %h required %h", m0_data_in, e);
                end
              end
            end else if (m0_data_in !== 16'h0) begin
              errors++;
              $display("FAIL m0_idle_data: got %h required 0000", m0_data_in);
            end
            checks++;
            if (m1_ready) begin
              if (exp1.size() == 0) begin
                errors++;
                $display("FAIL m1_extra_ready: ready=1 required no pending");
              end else begin
                e = exp1.pop_front();
                if (m1_data_in !== e) begin
                  errors++;
                  $display("FAIL m1_data: got %h required %h", m1_data_in, e);
                end
              end
            end else if (m1_data_in !== 16'h0) begin
              errors++;
              $display("FAIL m1_idle_data: got %h required 0000", m1_data_in);
            end
          end
        end
      end
    join_none
    test_reset();
    test_contention();
    test_single_read();
    test_single_write();
    test_persistent();
    test_abandon();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL pending: q0=%0d q1=%0d required 0/0", exp0.size(), exp1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
